serial_cmd_master: RTL
======================

Name: serial_cmd_master

Overview:
- Initiator end of the board serial command protocol.
- Accepts one command at a time from local logic: opcode, 0-4 argument bytes, expected reply length.
- Serialises the command through a byte UART transmitter, then collects the reply bytes from a UART receiver into a packed buffer, with an inter-byte timeout.
- Sits on the master/trigger board, driving the command port of downstream boards: firmware version (op 0), prescale (op 7), histo readout (op 10), and similar.

Parameters:
- MAXREPLY, 32, maximum reply bytes captured; reply buffer is 8*MAXREPLY bits.
- TIMEOUT_CYCLES, 1000000, clk cycles allowed before the first reply byte and between consecutive reply bytes.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high when idle; command accepted on cmd_valid&&cmd_ready
- cmd_op  in  8  opcode byte
- cmd_nargs  in  3  argument byte count, 0-4; values >4 clamp to 4
- cmd_args  in  32  arguments, sent LSB byte first ([7:0], then [15:8], ...)
- cmd_nreply  in  6  expected reply bytes; values >MAXREPLY clamp to MAXREPLY
- txBusy  in  1  UART transmitter busy
- txStart  out  1  one-cycle strobe to send txData
- txData  out  8  byte to transmit
- rxReady  in  1  one-cycle strobe, rxData valid
- rxData  in  8  received byte
- reply_valid  out  1  one-cycle pulse when a transaction ends
- reply_data  out  8*MAXREPLY  reply byte k in [8k+7:8k]
- reply_count  out  6  bytes actually received
- timeout_err  out  1  set with reply_valid if the transaction timed out; held until next accept
- busy  out  1  not idle

Behaviour:
- Reset values: txStart=0, txData=0, cmd_ready=1, busy=0, reply_valid=0, reply_data=0, reply_count=0, timeout_err=0. State machine goes to IDLE.
- Reset mid-transaction aborts immediately. No reply_valid is produced and no partial txStart is issued.
- States: IDLE, TX_WAIT, TX_GAP, RX_WAIT, DONE.
- IDLE: cmd_ready=1.
  - On accept: latch op, args, clamped nargs and nreply.
  - Clear reply_data, reply_count and timeout_err.
  - Set byte index to 0; total bytes to send = 1+nargs.
  - Go to TX_WAIT.
- TX_WAIT: when txBusy=0, drive txData with the current byte (index 0 = op, index n = args byte n-1) and assert txStart for exactly one cycle, then go to TX_GAP.
- TX_GAP: one cycle with txStart=0, giving the transmitter time to raise txBusy.
  - If more bytes remain: increment index, go to TX_WAIT.
  - Otherwise: load the timeout counter and go to RX_WAIT, or to DONE if nreply=0.
- Consecutive txStart strobes are therefore at least 2 cycles apart, and each is issued only when txBusy=0 in that cycle. txBusy held high stalls indefinitely; there is no timeout on the tx side.
- RX_WAIT:
  - On rxReady: write rxData to reply_data byte reply_count, increment reply_count, reload the timeout counter.
  - When reply_count reaches nreply, go to DONE.
  - Without rxReady: the counter decrements. When it expires (TIMEOUT_CYCLES cycles after entry or after the last byte), set timeout_err=1 and go to DONE.
  - rxReady in the same cycle as expiry: the byte is taken, no timeout that cycle.
- DONE: reply_valid=1 for one cycle, then go to IDLE. reply_data, reply_count and timeout_err hold until the next accept.
- rxReady outside RX_WAIT (stray or late bytes) is discarded; reply_data is not modified.
- cmd_valid while not idle is ignored (cmd_ready=0). A new command may be accepted in the cycle after DONE.
- Latency, nreply=0, idle transmitter: accept → first txStart in 1 cycle; reply_valid 2 cycles after the last txStart.

Test Plan:
- Version query: op=0x00, nargs=0, nreply=1; rx 0x05 after 200 cycles → txData 0x00 with one txStart; reply_valid with reply_data[7:0]=0x05, reply_count=1, timeout_err=0.
- Prescale write: op=0x07, nargs=4, args=0x12345678, nreply=0, txBusy modelled 10 cycles per byte → tx sequence 07,78,56,34,12, five strobes each ≥2 cycles apart and only when txBusy=0; reply_valid with count 0.
- Histo read: op=0x0A, nreply=32; rx bytes 0x00..0x1F spaced 50 cycles → reply_data byte k = k, reply_count=32, no error. A 33rd stray byte afterwards leaves reply_data unchanged.
- Timeout: TIMEOUT_CYCLES=100, nreply=4, rx 2 bytes then silence → reply_valid exactly 100 cycles after the second byte; timeout_err=1, reply_count=2, bytes 2-3 = 0.
- Clamping and stall: nargs=7, nreply=63 with MAXREPLY=32 → 5 bytes sent, at most 32 captured. txBusy held high 500 cycles → no txStart during the hold.
- Reset mid-transaction: assert reset during the third tx byte → outputs immediately return to reset values, no reply_valid; a new command after release completes normally.

Source files
------------

// File: rtl/serial_cmd_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_cmd_master: serial command initiator, UART tx of op+args, rx reply |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module serial_cmd_master #(
   parameter int MAXREPLY       = 32,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [7:0]            cmd_op,
   input  logic [2:0]            cmd_nargs,
   input  logic [31:0]           cmd_args,
   input  logic [5:0]            cmd_nreply,
   input  logic                  txBusy,
   output logic                  txStart,
   output logic [7:0]            txData,
   input  logic                  rxReady,
   input  logic [7:0]            rxData,
   output logic                  reply_valid,
   output logic [8*MAXREPLY-1:0] reply_data,
   output logic [5:0]            reply_count,
   output logic                  timeout_err,
   output logic                  busy
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   // Loaded one short so expiry lands exactly TIMEOUT_CYCLES after the reload.
   localparam logic [CW-1:0] C_TMO_LOAD = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      TX_WAIT = 3'd1,
      TX_GAP  = 3'd2,
      RX_WAIT = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t          state, state_nxt;
   logic [7:0]      r_op;
   logic [31:0]     r_args;
   logic [2:0]      r_nargs;
   logic [5:0]      r_nreply;
   logic [2:0]      r_idx;
   logic [CW-1:0]   r_tmo_cnt;

   logic            w_accept;
   logic            w_rx_take;
   logic            w_expire;
   logic            w_more_bytes;
   logic [7:0]      w_cur_byte;
   logic [2:0]      w_nargs_cl;
   logic [5:0]      w_nreply_cl;

   assign w_nargs_cl   = (cmd_nargs > 3'd4) ? 3'd4 : cmd_nargs;
   assign w_nreply_cl  = (cmd_nreply > 6'(MAXREPLY)) ? 6'(MAXREPLY) : cmd_nreply;
   assign w_more_bytes = (r_idx < r_nargs);
   assign busy         = (state != IDLE);

   always_comb begin
      case (r_idx)
         3'd0:    w_cur_byte = r_op;
         3'd1:    w_cur_byte = r_args[7:0];
         3'd2:    w_cur_byte = r_args[15:8];
         3'd3:    w_cur_byte = r_args[23:16];
         3'd4:    w_cur_byte = r_args[31:24];
         default: w_cur_byte = 8'h00;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      w_accept    = 1'b0;
      w_rx_take   = 1'b0;
      w_expire    = 1'b0;
      cmd_ready   = 1'b0;
      txStart     = 1'b0;
      txData      = 8'h00;
      reply_valid = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               w_accept  = 1'b1;
               state_nxt = TX_WAIT;
            end
         end
         TX_WAIT: begin
            txData = w_cur_byte;
            if (!txBusy) begin
               txStart   = 1'b1;
               state_nxt = TX_GAP;
            end
         end
         TX_GAP: begin
            if (w_more_bytes) begin
               state_nxt = TX_WAIT;
            end else if (r_nreply == 6'd0) begin
               state_nxt = DONE;
            end else begin
               state_nxt = RX_WAIT;
            end
         end
         RX_WAIT: begin
            // A byte arriving on the expiry cycle wins over the timeout.
            if (rxReady) begin
               w_rx_take = 1'b1;
               if (reply_count + 6'd1 == r_nreply) begin
                  state_nxt = DONE;
               end
            end else if (r_tmo_cnt <= CW'(1)) begin
               w_expire  = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            reply_valid = 1'b1;
            state_nxt   = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op        <= 8'h00;
         r_args      <= 32'h0;
         r_nargs     <= 3'd0;
         r_nreply    <= 6'd0;
         r_idx       <= 3'd0;
         r_tmo_cnt   <= '0;
         reply_data  <= '0;
         reply_count <= 6'd0;
         timeout_err <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op        <= cmd_op;
            r_args      <= cmd_args;
            r_nargs     <= w_nargs_cl;
            r_nreply    <= w_nreply_cl;
            r_idx       <= 3'd0;
            reply_data  <= '0;
            reply_count <= 6'd0;
            timeout_err <= 1'b0;
         end
         if (state == TX_GAP) begin
            if (w_more_bytes) begin
               r_idx <= r_idx + 3'd1;
            end else begin
               r_tmo_cnt <= C_TMO_LOAD;
            end
         end
         if (w_rx_take) begin
            for (int k = 0; k < MAXREPLY; k++) begin
               if (reply_count == 6'(k)) begin
                  reply_data[8*k +: 8] <= rxData;
               end
            end
            reply_count <= reply_count + 6'd1;
            r_tmo_cnt   <= C_TMO_LOAD;
         end else if (state == RX_WAIT) begin
            if (w_expire) begin
               timeout_err <= 1'b1;
            end else begin
               r_tmo_cnt <= r_tmo_cnt - CW'(1);
            end
         end
      end
   end

endmodule
`default_nettype wire
